spi_ram_ctrl: RTL

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

---
 rtl/spi_ram_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/spi_ram_ctrl.sv
// SPI-slave-side RAM controller: decodes 10-bit command words into address latches,
// writes and read requests, and holds read data on tx_data for a fixed window.
// Optional address auto-increment is enabled by defining ADDR_AUTO_INC_EN.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       drop_err,
    output logic [1:0] state_o
);

    // Handshake: rx_valid qualifies rx_data for exactly the cycle it is high and is
    // accepted only while the controller is idle (no back-pressure; extra commands are
    // dropped and flagged). tx_valid marks tx_data as stable for the whole hold window.

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RD_ACCESS = 2'd1,
        S_TX_HOLD   = 2'd2
    } state_e;

    localparam int                CNT_W     = $clog2(TX_HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(TX_HOLD);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 drop_err_q, drop_err_d;

    logic [7:0]           mem [MEM_DEPTH];

    logic [1:0]           opcode;
    logic [7:0]           payload;
    logic                 accept;
    logic                 mem_we;

    assign opcode  = rx_data[9:8];
    assign payload = rx_data[7:0];
    assign accept  = rx_valid && (state_q == S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && opcode == OP_READ) begin
                    state_d = S_RD_ACCESS;
                end
            end
            S_RD_ACCESS: begin
                state_d = S_TX_HOLD;
            end
            S_TX_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next-value logic
    always_comb begin
        busy       = (state_q != S_IDLE);
        drop_err_d = rx_valid && (state_q != S_IDLE);
        mem_we     = accept && (opcode == OP_WRITE);
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        tx_data_d  = tx_data_q;
        cnt_d      = '0;
        // tx_valid lags entry into the hold state by one cycle and drops as the state exits
        tx_valid_d = (state_q == S_TX_HOLD) && (cnt_q != HOLD_LAST);

        if (state_q == S_TX_HOLD && cnt_q != HOLD_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept && opcode == OP_WR_ADDR) begin
            wr_addr_d = payload[ADDR_SIZE-1:0];
        end
        if (accept && opcode == OP_RD_ADDR) begin
            rd_addr_d = payload[ADDR_SIZE-1:0];
        end

        if (state_q == S_RD_ACCESS) begin
            tx_data_d = mem[rd_addr_q];
        end

`ifdef ADDR_AUTO_INC_EN
        if (mem_we) begin
            wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
        end
        if (state_q == S_RD_ACCESS) begin
            rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Memory keeps its contents across reset; writes are blocked while reset is high
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[wr_addr_q] <= payload;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign drop_err = drop_err_q;
    assign state_o  = state_q;

endmodule
